// File: rtl/debug_pkg.sv
// Shared constants and types for the debug memory loader.
// Command bytes, response bytes, FSM state encoding and word/address types.
package debug_pkg;

  localparam logic [7:0] CmdLoadImem = 8'hA5;
  localparam logic [7:0] CmdLoadDmem = 8'h5A;
  localparam logic [7:0] CmdRun      = 8'hC3;

  localparam logic [7:0] AckByteDef  = 8'h06;
  localparam logic [7:0] NakByteDef  = 8'h15;

  typedef logic [31:0] DebugWordT;
  typedef logic [31:0] DebugAddrT;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_COUNT = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP  = 3'd4
  } debug_state_e;

  function automatic logic is_word_aligned(input DebugAddrT addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/debug_loader_if.sv
// UART byte handshake plus core debug write bus seen by the loader.
// The slave modport is the loader side; master is the UART/core side.
interface debug_loader_if;
  import debug_pkg::*;

  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       tx_ready_i;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       debug_o;
  DebugAddrT  debug_addr_o;
  DebugWordT  debug_data_o;
  logic       debug_imem_o;
  logic       debug_full_reset_o;

  modport slave (
    input  rx_valid_i, rx_data_i, tx_ready_i,
    output tx_valid_o, tx_data_o, debug_o, debug_addr_o, debug_data_o,
           debug_imem_o, debug_full_reset_o
  );

  modport master (
    output rx_valid_i, rx_data_i, tx_ready_i,
    input  tx_valid_o, tx_data_o, debug_o, debug_addr_o, debug_data_o,
           debug_imem_o, debug_full_reset_o
  );

endinterface

// File: rtl/debug_byte_assembler.sv
// Little-endian byte shifter: collects last_idx_i+1 bytes and strobes word_done_o
// on the final byte, presenting the completed word in that same cycle.
module debug_byte_assembler
  import debug_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_i,
  input  logic [1:0] last_idx_i,
  output DebugWordT  word_o,
  output logic       word_done_o
);

  logic [23:0] shift_q;
  logic [23:0] shift_d;
  logic [1:0]  idx_q;
  logic [1:0]  idx_d;

  // Newest byte lands in the top lane; a 2-byte field therefore sits in word_o[31:16].
  assign word_o      = {byte_i, shift_q};
  assign word_done_o = byte_valid_i && (idx_q == last_idx_i);

  // next-state for shift register and byte index
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = 24'h00_0000;
      idx_d   = 2'd0;
    end else if (byte_valid_i) begin
      shift_d = {byte_i, shift_q[23:8]};
      idx_d   = word_done_o ? 2'd0 : (idx_q + 2'd1);
    end else begin
      shift_d = shift_q;
      idx_d   = idx_q;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= 24'h00_0000;
      idx_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/debug_loader.sv
// Framed UART load controller: parses commands, writes words into IMEM/DMEM
// through the core debug port and answers each frame with an ACK or NAK byte.
module debug_loader
  import debug_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1_000_000,
  parameter logic [7:0]  AckByte       = AckByteDef,
  parameter logic [7:0]  NakByte       = NakByteDef
) (
  input  logic           clk,
  input  logic           reset,
  debug_loader_if.slave  bus,
  output logic           busy_o,
  output logic           err_o
);

  localparam logic [2:0]  StIdle      = ST_IDLE;
  localparam logic [2:0]  StAddr      = ST_ADDR;
  localparam logic [2:0]  StCount     = ST_COUNT;
  localparam logic [2:0]  StData      = ST_DATA;
  localparam logic [2:0]  StResp      = ST_RESP;
  localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);

  logic [2:0]  state_q,      state_d;
  DebugAddrT   addr_q,       addr_d;
  logic [15:0] remain_q,     remain_d;
  logic        imem_q,       imem_d;
  logic        last_wr_q,    last_wr_d;
  logic [31:0] timer_q,      timer_d;
  logic        full_reset_q, full_reset_d;
  logic        debug_q,      debug_d;
  DebugAddrT   dbg_addr_q,   dbg_addr_d;
  DebugWordT   dbg_data_q,   dbg_data_d;
  logic        dbg_imem_q,   dbg_imem_d;
  logic        tx_valid_q,   tx_valid_d;
  logic [7:0]  tx_data_q,    tx_data_d;
  logic        err_q,        err_d;
  logic        busy_q;

  logic        in_field_s;
  logic        timeout_s;
  logic        asm_clear_s;
  logic        asm_valid_s;
  logic [1:0]  asm_last_s;
  DebugWordT   asm_word_s;
  logic        asm_done_s;

  assign in_field_s  = (state_q == StAddr) || (state_q == StCount) || (state_q == StData);
  // The cycle carrying the final write pulse is not a field byte slot.
  assign asm_clear_s = !in_field_s || last_wr_q;
  assign asm_valid_s = in_field_s && !last_wr_q && bus.rx_valid_i;
  assign asm_last_s  = (state_q == StCount) ? 2'd1 : 2'd3;
  assign timeout_s   = in_field_s && !last_wr_q && !bus.rx_valid_i && (timer_q == TimeoutLast);

  debug_byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (asm_clear_s),
    .byte_valid_i (asm_valid_s),
    .byte_i       (bus.rx_data_i),
    .last_idx_i   (asm_last_s),
    .word_o       (asm_word_s),
    .word_done_o  (asm_done_s)
  );

  // frame FSM, write-port and response next-state logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    imem_d       = imem_q;
    last_wr_d    = last_wr_q;
    full_reset_d = full_reset_q;
    debug_d      = 1'b0;
    dbg_addr_d   = dbg_addr_q;
    dbg_data_d   = dbg_data_q;
    dbg_imem_d   = dbg_imem_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    err_d        = 1'b0;

    if (bus.rx_valid_i || !in_field_s) begin
      timer_d = 32'd0;
    end else begin
      timer_d = timer_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        if (bus.rx_valid_i) begin
          case (bus.rx_data_i)
            CmdLoadImem, CmdLoadDmem: begin
              imem_d       = (bus.rx_data_i == CmdLoadImem);
              full_reset_d = 1'b1;
              state_d      = StAddr;
            end
            CmdRun: begin
              full_reset_d = 1'b0;
              state_d      = StResp;
              tx_valid_d   = 1'b1;
              tx_data_d    = AckByte;
            end
            default: begin
              state_d    = StResp;
              tx_valid_d = 1'b1;
              tx_data_d  = NakByte;
              err_d      = 1'b1;
            end
          endcase
        end else begin
          state_d = StIdle;
        end
      end
      StAddr: begin
        if (timeout_s || (asm_done_s && !is_word_aligned(asm_word_s))) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = NakByte;
          err_d      = 1'b1;
        end else if (asm_done_s) begin
          addr_d  = asm_word_s;
          state_d = StCount;
        end else begin
          state_d = StAddr;
        end
      end
      StCount: begin
        if (timeout_s) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = NakByte;
          err_d      = 1'b1;
        end else if (asm_done_s && (asm_word_s[31:16] == 16'd0)) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = AckByte;
        end else if (asm_done_s) begin
          remain_d = asm_word_s[31:16];
          state_d  = StData;
        end else begin
          state_d = StCount;
        end
      end
      StData: begin
        if (last_wr_q) begin
          last_wr_d  = 1'b0;
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = AckByte;
        end else if (timeout_s) begin
          state_d    = StResp;
          tx_valid_d = 1'b1;
          tx_data_d  = NakByte;
          err_d      = 1'b1;
        end else if (asm_done_s) begin
          debug_d    = 1'b1;
          dbg_addr_d = addr_q;
          dbg_data_d = asm_word_s;
          dbg_imem_d = imem_q;
          addr_d     = addr_q + 32'd4;
          remain_d   = remain_q - 16'd1;
          last_wr_d  = (remain_q == 16'd1);
        end else begin
          state_d = StData;
        end
      end
      StResp: begin
        if (bus.tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end else begin
          state_d = StResp;
        end
      end
      default: begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
        last_wr_d  = 1'b0;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= 32'h0000_0000;
      remain_q     <= 16'd0;
      imem_q       <= 1'b0;
      last_wr_q    <= 1'b0;
      timer_q      <= 32'd0;
      full_reset_q <= 1'b1;
      debug_q      <= 1'b0;
      dbg_addr_q   <= 32'h0000_0000;
      dbg_data_q   <= 32'h0000_0000;
      dbg_imem_q   <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      imem_q       <= imem_d;
      last_wr_q    <= last_wr_d;
      timer_q      <= timer_d;
      full_reset_q <= full_reset_d;
      debug_q      <= debug_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_data_q   <= dbg_data_d;
      dbg_imem_q   <= dbg_imem_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign bus.tx_valid_o         = tx_valid_q;
  assign bus.tx_data_o          = tx_data_q;
  assign bus.debug_o            = debug_q;
  assign bus.debug_addr_o       = dbg_addr_q;
  assign bus.debug_data_o       = dbg_data_q;
  assign bus.debug_imem_o       = dbg_imem_q;
  assign bus.debug_full_reset_o = full_reset_q;
  assign busy_o                 = busy_q;
  assign err_o                  = err_q;

endmodule
